counter8b: RTL and testbench
============================

COUNTER8B -- requirements
Module: counter8b

Interface
REQ-001 Parameter: WIDTH, default 8, counter and data width in bits; all width rules below use WIDTH.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk only.
REQ-003 rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 ld_en  input  1  parallel-load enable, active-high.
REQ-005 en  input  1  count enable, active-high.
REQ-006 updwn  input  1  count direction: 1 = up (+1), 0 = down (-1).
REQ-007 datain  input  WIDTH  parallel-load value.
REQ-008 dataout  output  WIDTH  current count, driven directly from the count register.

Function
REQ-009 Single WIDTH-bit count register; dataout equals the register at all times, with no combinational path from any input to dataout.
REQ-010 Per posedge clk, priority order: rst_n low > ld_en high > en high > hold.
REQ-011 Load: rst_n=1, ld_en=1 -> register <= datain at that edge, regardless of en and updwn; dataout shows datain one edge after sampling.
REQ-012 Count up: rst_n=1, ld_en=0, en=1, updwn=1 -> register <= register + 1 (mod 2^WIDTH).
REQ-013 Count down: rst_n=1, ld_en=0, en=1, updwn=0 -> register <= register - 1 (mod 2^WIDTH).
REQ-014 Hold: rst_n=1, ld_en=0, en=0 -> register unchanged; updwn and datain ignored.
REQ-015 Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1; no saturation, no flag, no stall.
REQ-016 A direction change (updwn toggle) takes effect on the next enabled edge with no lost or extra count.
REQ-017 Simultaneous ld_en=1 and en=1: load wins; no increment or decrement that cycle.
REQ-018 Counting starts from the loaded value on the edge after the load edge.
REQ-019 X on datain or updwn while it is ignored (REQ-014, REQ-017) shall not corrupt the register.

Reset
REQ-020 rst_n sampled low at posedge clk -> register <= 0, overriding ld_en, en and updwn.
REQ-021 Reset asserted mid-count forces 0 on that edge; after rst_n returns high, operation resumes from 0 per REQ-010.
REQ-022 No asynchronous reset path; before the first reset edge, dataout is undefined.
REQ-023 While rst_n is held low, dataout stays 0 on every edge.

Structure
REQ-024 Shared package counter_pkg holds the default WIDTH constant (8) and a count_t typedef (WIDTH-bit logic vector); counter8b imports it.
REQ-025 Single flat module, no sub-modules; next-state computation is one priority-ordered combinational block feeding one register.
REQ-026 Immediate assertions shall remain synthesis-off.

Verification
REQ-027 Reset: rst_n=0 for 2 edges with ld_en=1, en=1, datain=0x64 -> dataout=0x00 after the first edge and held at 0x00.
REQ-028 Load: rst_n=1, ld_en=1, datain=0x64 -> dataout=100 after one edge; still 100 with ld_en=1, en=1, updwn=1 (load priority).
REQ-029 Down/up count: from 100, ld_en=0, en=1, updwn=0 for 5 edges -> 95; then updwn=1 for 5 edges -> 100; each edge differs from $past by exactly 1.
REQ-030 Wrap: load 0x00, count down 1 edge -> 0xFF; load 0xFF, count up 1 edge -> 0x00.
REQ-031 Hold: from 42, en=0, ld_en=0 with updwn and datain toggling for 4 edges -> dataout stays 42.
REQ-032 Reset mid-operation: counting up at 7, rst_n=0 for one edge -> 0; rst_n=1, en=1, updwn=1 -> 1 on the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   COUNT_WIDTH - default counter/data width in bits
//   count_t     - COUNT_WIDTH-bit count value
//   cnt_op_e    - operation chosen for an edge, in priority order
package counter_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  // The action the counter takes on a given edge. The order of the
  // enumerators mirrors the priority of the controlling inputs.
  typedef enum logic [2:0] {
    OP_RESET = 3'd0,
    OP_LOAD  = 3'd1,
    OP_UP    = 3'd2,
    OP_DOWN  = 3'd3,
    OP_HOLD  = 3'd4
  } cnt_op_e;

  // Resolve the controlling inputs into a single operation. rst_n is
  // active-low; everything else is active-high. updwn is consulted only
  // when counting, so an unknown updwn on a load/hold/reset edge is harmless.
  function automatic cnt_op_e decode_op(input logic rst_n,
                                        input logic ld_en,
                                        input logic en,
                                        input logic updwn);
    cnt_op_e op;
    if (!rst_n) begin
      op = OP_RESET;
    end else if (ld_en) begin
      op = OP_LOAD;
    end else if (en) begin
      op = updwn ? OP_UP : OP_DOWN;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage : counter_pkg

// File: rtl/counter8b.sv
// Loadable up/down counter with synchronous active-low reset.
// Latency: one clk edge from sampled inputs to dataout; dataout is the register itself.
// Backpressure: none; the counter accepts a command on every edge and never stalls.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset, clears the count
//   ld_en   - parallel load of datain (beats en)
//   en      - count enable
//   updwn   - direction when counting: 1 = +1, 0 = -1
//   datain  - parallel-load value
//   dataout - current count, straight from the register
module counter8b
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic             en,
  input  logic             updwn,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  cnt_op_e          op;

  assign op = decode_op(rst_n, ld_en, en, updwn);

  // Next-state selection. Arithmetic wraps naturally in WIDTH bits, so
  // up from all-ones gives zero and down from zero gives all-ones.
  // datain is only routed through on a load, so its value on any other
  // edge never reaches the register.
  always_comb begin
    count_nxt = count_q;
    unique case (op)
      OP_RESET: count_nxt = '0;
      OP_LOAD:  count_nxt = datain;
      OP_UP:    count_nxt = count_q + ONE;
      OP_DOWN:  count_nxt = count_q - ONE;
      OP_HOLD:  count_nxt = count_q;
      default:  count_nxt = count_q;
    endcase
  end

  // The reset is folded into the next-state block above, so the register
  // itself has no reset term and no asynchronous path.
  always_ff @(posedge clk) begin
    count_q <= count_nxt;
  end

  assign dataout = count_q;

`ifndef SYNTHESIS
  // Out of reset, the controls that pick load/count/hold must be known,
  // otherwise the register would take an undefined value.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ctrl_known_a: assert (!$isunknown({ld_en, en}));
      if (!ld_en && en) begin
        dir_known_a: assert (!$isunknown(updwn));
      end
    end
  end
`endif

endmodule : counter8b

// File: tb/tb_counter8b.sv
// Scoreboard bench for counter8b: directed scenarios followed by random traffic.
// Inputs change on the falling edge; results are checked 1 time unit after the rising edge.
// The reference model tracks the count as a plain integer modulo 2^WIDTH.
module tb_counter8b;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             ld_en;
  logic             en;
  logic             updwn;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;

  counter8b #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (ld_en),
    .en      (en),
    .updwn   (updwn),
    .datain  (datain),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    value;
    string name;
  } exp_t;

  exp_t exp_q[$];

  int model;          // expected count, valid once the first reset edge is issued
  bit model_valid;
  int vectors;
  int miscompares;

  // Apply one edge's worth of inputs and record what the counter must read
  // after that edge. Before the first reset the count is undefined, so no
  // expectation is queued until reset has been seen.
  task automatic step(input bit r_n, input bit ld, input bit ce,
                      input bit ud, input int din, input string name);
    exp_t e;
    @(negedge clk);
    rst_n  = r_n;
    ld_en  = ld;
    en     = ce;
    updwn  = ud;
    datain = din[WIDTH-1:0];
    if (!r_n) begin
      model       = 0;
      model_valid = 1'b1;
    end else if (ld) begin
      model = din % MOD;
    end else if (ce) begin
      if (ud) model = (model + 1) % MOD;
      else    model = (model + MOD - 1) % MOD;
    end
    if (model_valid) begin
      e.value = model;
      e.name  = name;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: after each rising edge, the oldest outstanding expectation
  // belongs to that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (int'(dataout) != e.value) begin
          miscompares++;
          $display("FAIL %s: dataout=0x%0h expected=0x%0h at %0t",
                   e.name, dataout, e.value, $time);
        end
      end
    end
  end

  initial begin
    int drain;
    vectors     = 0;
    miscompares = 0;
    model       = 0;
    model_valid = 1'b0;
    rst_n  = 1'b1;
    ld_en  = 1'b0;
    en     = 1'b0;
    updwn  = 1'b0;
    datain = '0;

    // Reset overrides a concurrent load and count.
    step(0, 1, 1, 1, 'h64, "reset_edge1");
    step(0, 1, 1, 1, 'h64, "reset_edge2");

    // Load, then load again while en is also high: load wins.
    step(1, 1, 0, 0, 'h64, "load_100");
    step(1, 1, 1, 1, 'h64, "load_priority");

    // Five down then five up, direction change with no lost count.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 'h00, "count_down");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 'h00, "count_up");

    // Wrap in both directions.
    step(1, 1, 0, 0, 'h00, "load_00");
    step(1, 0, 1, 0, 'h00, "wrap_down");
    step(1, 1, 0, 0, 'hFF, "load_ff");
    step(1, 0, 1, 1, 'h00, "wrap_up");

    // Hold at 42 while ignored inputs toggle.
    step(1, 1, 0, 0, 42, "load_42");
    for (int i = 0; i < 4; i++) step(1, 0, 0, i[0], (i[0] ? 'hA5 : 'h5A), "hold");

    // Reset in the middle of counting, then resume from zero.
    step(1, 1, 0, 0, 6, "load_6");
    step(1, 0, 1, 1, 0, "up_to_7");
    step(0, 0, 1, 1, 0, "mid_reset");
    step(1, 0, 1, 1, 0, "resume_from_0");

    // Random traffic, including occasional reset and frequent wrap.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1),
           int'($urandom_range(0, MOD - 1)),
           "random");
    end

    // Let the monitor drain; a stuck queue is itself a failure.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: outstanding=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_counter8b
